// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: accepts load/store commands, runs a req/ack handshake with data memory,
// and returns load data with a one-cycle valid. Optional REQ timeout is enabled by defining MEM_ACC_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 32,
    parameter int                TIMEOUT_CYCLES = 16,
    parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              enable_mem,
    input  logic [2:0]        opselect,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0] mem_wdata_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] mem_data_read_in,
    output logic              control_out,
    output logic              busy,
    output logic              err,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_READ  = 3'b101;
    localparam logic [2:0] OP_WRITE = 3'b100;

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ctrl;
    logic              r_err;

    logic w_is_op;
    logic w_accept;
    logic w_aligned;
    logic w_timeout;

    assign w_is_op   = (opselect == OP_READ) || (opselect == OP_WRITE);
    assign w_accept  = (r_state != S_REQ) && enable_mem && w_is_op;
    assign w_aligned = (mem_addr_in[1:0] == 2'b00);

`ifdef MEM_ACC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // The limit is reached on the edge that would bring the wait count up to TIMEOUT_CYCLES; an ack on that edge wins.
    assign w_timeout = (r_state == S_REQ) && !dmem_ack && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_cnt <= '0;
        end else if (w_accept && w_aligned) begin
            r_cnt <= '0;
        end else if ((r_state == S_REQ) && !dmem_ack) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{ERR_DATA, 32'(TIMEOUT_CYCLES)};
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = (w_accept && w_aligned) ? S_REQ : S_IDLE;
            S_REQ:          w_next = (dmem_ack || w_timeout) ? S_DONE : S_REQ;
            default:        w_next = S_IDLE;
        endcase
    end

    // Handshake: dmem_req rises the cycle after accept and stays high with we/addr/wdata frozen until the
    // edge that samples dmem_ack=1; dmem_ack seen in any other state is ignored.
    always_comb begin
        dmem_req = 1'b0;
        busy     = 1'b0;
        if (r_state == S_REQ) begin
            dmem_req = 1'b1;
            busy     = 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ctrl  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ctrl <= 1'b0;
            r_err  <= 1'b0;
            if (w_accept) begin
                if (w_aligned) begin
                    r_we    <= (opselect == OP_WRITE);
                    r_addr  <= mem_addr_in;
                    r_wdata <= mem_wdata_in;
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == S_REQ) begin
                if (dmem_ack) begin
                    if (!r_we) begin
                        r_rdata <= dmem_rdata;
                        r_ctrl  <= 1'b1;
                    end
                end else if (w_timeout) begin
                    r_err <= 1'b1;
`ifdef MEM_ACC_TIMEOUT_EN
                    if (!r_we) begin
                        r_rdata <= ERR_DATA;
                    end
`endif
                end
            end
        end
    end

    assign dmem_we          = r_we;
    assign dmem_addr        = r_addr;
    assign dmem_wdata       = r_wdata;
    assign mem_data_read_in = r_rdata;
    assign control_out      = r_ctrl;
    assign err              = r_err;
    assign o_dbg_state      = r_state;

endmodule
